// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave
// Purpose  : SPI mode-0 target (CPOL=0, CPHA=0), MSB first, 8-bit frames.
//            SPI pins are oversampled in the CLK1 domain through 2-flop
//            synchronizers; SCK/SS edges come from comparing stage 2 with a
//            third registered copy. CLK1 must run at least 8x SPI_SCK.
// Ports    : CLK1, RESET_N         - system clock, async active-low reset
//            SPI_SCK/SS/SDI        - asynchronous pins from the master
//            SPI_SDO, sdo_oe       - MISO data and its pad output enable
//            tx_data, tx_load      - byte to send next and its load strobe
//            tx_pending            - transmit buffer holds an unsent byte
//            rx_data, rx_valid     - last received byte and its 1-cycle pulse
//            active                - a frame is being serviced (SS low)
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave #(
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic       CLK1,
  input  logic       RESET_N,
  input  logic       SPI_SCK,
  input  logic       SPI_SS,
  input  logic       SPI_SDI,
  output logic       SPI_SDO,
  output logic       sdo_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_pending,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       active
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  // Synchronizers (stage 3 exists only for edge detection)
  logic        r_sck_s1, r_sck_s2, r_sck_s3;
  logic        r_ss_s1,  r_ss_s2,  r_ss_s3;
  logic        r_sdi_s1, r_sdi_s2;

  // r_warm fills with ones after reset; once r_warm[1] is set, stage 2 holds
  // a genuine pin sample rather than its reset value.
  logic [1:0]  r_warm;
  // Set once SS has really been seen high after reset. Without it, a frame
  // already in progress at reset release would look like a falling SS edge.
  logic        r_armed;

  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_rx_shift;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic [7:0]  r_tx_buf;
  logic        r_tx_pending;
  logic [7:0]  r_tx_shift;
  logic        r_sdo_oe;

  logic        w_sck_rise, w_sck_fall, w_ss_fall, w_ss_rise;
  logic        w_start, w_stop, w_rise, w_fall, w_fall_reload, w_consume;
  logic [7:0]  w_tx_next;

  assign w_sck_rise    =  r_sck_s2 & ~r_sck_s3;
  assign w_sck_fall    = ~r_sck_s2 &  r_sck_s3;
  assign w_ss_fall     = ~r_ss_s2  &  r_ss_s3 & r_armed;
  assign w_ss_rise     =  r_ss_s2  & ~r_ss_s3;

  assign w_start       = (r_state == ST_IDLE)  & w_ss_fall;
  assign w_stop        = (r_state == ST_SHIFT) & w_ss_rise;
  assign w_rise        = (r_state == ST_SHIFT) & w_sck_rise & ~w_stop;
  assign w_fall        = (r_state == ST_SHIFT) & w_sck_fall & ~w_stop;
  assign w_fall_reload = w_fall & (r_bit_cnt == 3'd0);
  assign w_consume     = r_tx_pending & (w_start | w_fall_reload);
  assign w_tx_next     = r_tx_pending ? r_tx_buf : IDLE_BYTE;

  // State register
  always_ff @(posedge CLK1 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_ss_fall) w_state_next = ST_SHIFT;
      ST_SHIFT: if (w_ss_rise) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Synchronizers and datapath
  always_ff @(posedge CLK1 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sck_s1     <= 1'b0;
      r_sck_s2     <= 1'b0;
      r_sck_s3     <= 1'b0;
      r_ss_s1      <= 1'b1;
      r_ss_s2      <= 1'b1;
      r_ss_s3      <= 1'b1;
      r_sdi_s1     <= 1'b0;
      r_sdi_s2     <= 1'b0;
      r_warm       <= 2'b00;
      r_armed      <= 1'b0;
      r_bit_cnt    <= 3'd0;
      r_rx_shift   <= 8'h00;
      r_rx_data    <= 8'h00;
      r_rx_valid   <= 1'b0;
      r_tx_buf     <= 8'h00;
      r_tx_pending <= 1'b0;
      r_tx_shift   <= IDLE_BYTE;
      r_sdo_oe     <= 1'b0;
    end else begin
      r_sck_s1 <= SPI_SCK;
      r_sck_s2 <= r_sck_s1;
      r_sck_s3 <= r_sck_s2;
      r_ss_s1  <= SPI_SS;
      r_ss_s2  <= r_ss_s1;
      r_ss_s3  <= r_ss_s2;
      r_sdi_s1 <= SPI_SDI;
      r_sdi_s2 <= r_sdi_s1;

      r_warm <= {r_warm[0], 1'b1};
      if (r_warm[1] && r_ss_s2) begin
        r_armed <= 1'b1;
      end

      r_rx_valid <= 1'b0;

      // A load coinciding with consumption keeps pending high: the old byte
      // is taken via w_tx_next while the new one lands in the buffer.
      if (tx_load) begin
        r_tx_buf     <= tx_data;
        r_tx_pending <= 1'b1;
      end else if (w_consume) begin
        r_tx_pending <= 1'b0;
      end

      if (w_start) begin
        r_bit_cnt  <= 3'd0;
        r_rx_shift <= 8'h00;
        r_tx_shift <= w_tx_next;
        r_sdo_oe   <= 1'b1;
      end else if (w_stop) begin
        // Any partial byte is simply dropped; rx_data keeps its old value.
        r_bit_cnt <= 3'd0;
        r_sdo_oe  <= 1'b0;
      end else begin
        if (w_rise) begin
          r_rx_shift <= {r_rx_shift[6:0], r_sdi_s2};
          r_bit_cnt  <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            r_rx_data  <= {r_rx_shift[6:0], r_sdi_s2};
            r_rx_valid <= 1'b1;
          end
        end
        // Falling edge at the byte boundary presents the next byte's MSB.
        if (w_fall) begin
          if (w_fall_reload) begin
            r_tx_shift <= w_tx_next;
          end else begin
            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
          end
        end
      end
    end
  end

  assign SPI_SDO    = r_sdo_oe & r_tx_shift[7];
  assign sdo_oe     = r_sdo_oe;
  assign tx_pending = r_tx_pending;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  // Tracks the serviced frame, so a frame joined mid-way at reset release
  // does not report active.
  assign active     = (r_state == ST_SHIFT);

endmodule
`default_nettype wire
